// File: rtl/score_tracker.sv
// Frame-clocked game score engine: weighted hits, timed x2/x4 multipliers, idle/play/won
// sequencing, session high score, and a bit-serial double-dabble BCD display converter.
module score_tracker #(
  parameter int SCORE_W    = 14,
  parameter int WIN_SCORE  = 1000,
  parameter int HIT_PTS    = 1,
  parameter int BONUS_PTS  = 10,
  parameter int TIMER_W    = 9,
  parameter int MULT_TICKS = 511,
  parameter int NUM_DIG    = 5
) (
  input  logic                   frame_clk,
  input  logic                   Reset_n,
  input  logic                   start_game,
  input  logic                   pause,
  input  logic                   hit,
  input  logic                   hit_bonus,
  input  logic                   pu_valid,
  input  logic [1:0]             pu_type,
  output logic [SCORE_W-1:0]     score,
  output logic [SCORE_W-1:0]     high_score,
  output logic [2:0]             mult,
  output logic [TIMER_W-1:0]     mult_timer,
  output logic                   win_game,
  output logic                   new_high,
  output logic [4*NUM_DIG-1:0]   score_bcd,
  output logic                   bcd_valid
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_WON  = 2'd2;

  localparam int SUM_W = SCORE_W + 4;
  localparam int CNT_W = $clog2(SCORE_W + 1);
  localparam logic [SUM_W-1:0]   SAT_MAX   = SUM_W'((1 << SCORE_W) - 1);
  localparam logic [SCORE_W-1:0] SAT_SCORE = SCORE_W'((1 << SCORE_W) - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);

  logic [1:0]         state;
  logic [SUM_W-1:0]   pts;
  logic [SUM_W-1:0]   sum;
  logic [SCORE_W-1:0] sat_score;
  logic [SCORE_W-1:0] next_score;
  logic               pu_take;
  logic               reach_win;
  logic               leave_play;

  // NOTE: every signal assigned in always_comb gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    pts = '0;
    if (hit)       pts = pts + SUM_W'(HIT_PTS);
    if (hit_bonus) pts = pts + SUM_W'(BONUS_PTS);
    sum        = {4'b0000, score} + pts * SUM_W'(mult);
    sat_score  = (sum > SAT_MAX) ? SAT_SCORE : sum[SCORE_W-1:0];
    next_score = pause ? score : sat_score;
    pu_take    = pu_valid && (pu_type == 2'b01 || pu_type == 2'b10);
    reach_win  = (next_score >= WIN_VAL);
    leave_play = reach_win || !start_game;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the values
  // from before the edge, independent of statement order.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= ST_IDLE;
      score      <= '0;
      high_score <= '0;
      mult       <= 3'd1;
      mult_timer <= '0;
      win_game   <= 1'b0;
      new_high   <= 1'b0;
    end else begin
      new_high <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_game) begin
            state      <= ST_PLAY;
            score      <= '0;
            mult       <= 3'd1;
            mult_timer <= '0;
          end
        end
        ST_PLAY: begin
          if (!pause) begin
            score <= sat_score;
            // A pickup takes effect from the next edge; this frame's hits used the old mult.
            if (pu_take) begin
              mult       <= (pu_type == 2'b01) ? 3'd2 : 3'd4;
              mult_timer <= TIMER_W'(MULT_TICKS);
            end else if (mult_timer != '0) begin
              mult_timer <= mult_timer - 1'b1;
              if (mult_timer == TIMER_W'(1)) mult <= 3'd1;
            end
          end
          if (reach_win) begin
            state    <= ST_WON;
            win_game <= 1'b1;
          end else if (!start_game) begin
            state <= ST_IDLE;
          end
          if (leave_play && next_score > high_score) begin
            high_score <= next_score;
            new_high   <= 1'b1;
          end
        end
        ST_WON: begin
          if (!start_game) begin
            state    <= ST_IDLE;
            win_game <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Display converter: captures the score, shifts one bit per frame, then publishes.
  logic [SCORE_W-1:0]   score_prev;
  logic [SCORE_W-1:0]   bin_sh;
  logic [4*NUM_DIG-1:0] bcd_sh;
  logic [4*NUM_DIG-1:0] bcd_adj;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 conv_busy;
  logic                 pending;
  logic                 score_changed;

  assign score_changed = (score != score_prev);

  always_comb begin
    bcd_adj = bcd_sh;
    for (int d = 0; d < NUM_DIG; d++) begin
      if (bcd_sh[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_sh[4*d +: 4] + 4'd3;
    end
  end

  // NOTE: the shift registers are reset along with the control bits; they are plain flops,
  // not a RAM, and a clean reset keeps the published digits at zero after an abort.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      score_prev <= '0;
      bin_sh     <= '0;
      bcd_sh     <= '0;
      bit_cnt    <= '0;
      conv_busy  <= 1'b0;
      pending    <= 1'b0;
      score_bcd  <= '0;
      bcd_valid  <= 1'b0;
    end else begin
      score_prev <= score;
      bcd_valid  <= 1'b0;
      if (!conv_busy) begin
        if (score_changed || pending) begin
          bin_sh    <= score;
          bcd_sh    <= '0;
          bit_cnt   <= CNT_W'(SCORE_W);
          conv_busy <= 1'b1;
          pending   <= 1'b0;
        end
      end else begin
        if (score_changed) pending <= 1'b1;
        if (bit_cnt != '0) begin
          {bcd_sh, bin_sh} <= {bcd_adj, bin_sh} << 1;
          bit_cnt          <= bit_cnt - 1'b1;
        end else begin
          score_bcd <= bcd_sh;
          bcd_valid <= 1'b1;
          conv_busy <= 1'b0;
        end
      end
    end
  end

endmodule
